// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: steps PC, instruction memory and IR through a
// fetch, hands the IR to the control unit and arbitrates PC redirects.
module fetch_sequencer #(
  parameter int unsigned IM_LAT = 1,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             ir_ack,
  input  logic             br_req,
  input  logic             jmp_req,
  input  logic             vec_req,
  input  logic             jr_req,
  output logic             PC_ld,
  output logic             PC_inc,
  output logic [1:0]       PC_sel,
  output logic             IM_cs,
  output logic             IM_rd,
  output logic             IR_ld,
  output logic             ir_valid,
  output logic             redir_ack,
  output logic             busy,
  output logic [CNT_W-1:0] fetch_cnt
);

  localparam int unsigned LAT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_LATCH = 3'd3,
    S_HOLD  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               redir_any;

  assign redir_any = br_req | jmp_req | vec_req | jr_req;

  // State, latency counter and fetch counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      lat_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; WAIT leaves once the decremented count reaches zero.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        lat_d   = LAT_W'(IM_LAT - 1);
        state_d = (IM_LAT == 1) ? S_LATCH : S_WAIT;
      end
      S_WAIT: begin
        lat_d = lat_q - LAT_W'(1);
        if (lat_q == LAT_W'(1)) state_d = S_LATCH;
      end
      S_LATCH: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (ir_ack) state_d = run ? S_FETCH : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; redirect strobes are Mealy on ir_ack in HOLD.
  always_comb begin
    PC_ld     = 1'b0;
    PC_inc    = 1'b0;
    PC_sel    = 2'b00;
    IM_cs     = 1'b0;
    IM_rd     = 1'b0;
    IR_ld     = 1'b0;
    ir_valid  = 1'b0;
    redir_ack = 1'b0;
    busy      = 1'b0;
    fetch_cnt = '0;
    if (!reset) begin
      busy      = (state_q != S_IDLE);
      fetch_cnt = cnt_q;
      unique case (state_q)
        S_FETCH, S_WAIT: begin
          IM_cs = 1'b1;
          IM_rd = 1'b1;
        end
        S_LATCH: begin
          IM_cs  = 1'b1;
          IM_rd  = 1'b1;
          IR_ld  = 1'b1;
          PC_inc = 1'b1;
        end
        S_HOLD: begin
          ir_valid = 1'b1;
          if (ir_ack && redir_any) begin
            PC_ld     = 1'b1;
            redir_ack = 1'b1;
            if (vec_req)      PC_sel = 2'b10;
            else if (jr_req)  PC_sel = 2'b11;
            else if (jmp_req) PC_sel = 2'b01;
            else              PC_sel = 2'b00;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: three instances (IM_LAT 1/2/3) share stimulus and
// are checked every cycle against a fetch-position model plus literal checks.
module tb_fetch_sequencer;

  logic clk;
  logic reset, run, ir_ack, br_req, jmp_req, vec_req, jr_req;

  logic       pc_ld [3];
  logic       pc_inc [3];
  logic [1:0] pc_sel [3];
  logic       im_cs [3];
  logic       im_rd [3];
  logic       ir_ld [3];
  logic       ir_valid [3];
  logic       redir_ack [3];
  logic       busy [3];
  logic [3:0]  cnt0;
  logic [31:0] cnt1, cnt2;

  int total, bad;

  // Model: idle, or busy at position 0..lat (memory access, lat = IR load), lat+1 = holding.
  logic        m_busy [3];
  int          m_pos [3];
  logic [31:0] m_cnt [3];

  logic [3:0] pats [4];
  logic [1:0] sels [4];

  fetch_sequencer #(.IM_LAT(1), .CNT_W(4)) u0 (
    .clk(clk), .reset(reset), .run(run), .ir_ack(ir_ack),
    .br_req(br_req), .jmp_req(jmp_req), .vec_req(vec_req), .jr_req(jr_req),
    .PC_ld(pc_ld[0]), .PC_inc(pc_inc[0]), .PC_sel(pc_sel[0]),
    .IM_cs(im_cs[0]), .IM_rd(im_rd[0]), .IR_ld(ir_ld[0]),
    .ir_valid(ir_valid[0]), .redir_ack(redir_ack[0]), .busy(busy[0]),
    .fetch_cnt(cnt0)
  );

  fetch_sequencer #(.IM_LAT(2), .CNT_W(32)) u1 (
    .clk(clk), .reset(reset), .run(run), .ir_ack(ir_ack),
    .br_req(br_req), .jmp_req(jmp_req), .vec_req(vec_req), .jr_req(jr_req),
    .PC_ld(pc_ld[1]), .PC_inc(pc_inc[1]), .PC_sel(pc_sel[1]),
    .IM_cs(im_cs[1]), .IM_rd(im_rd[1]), .IR_ld(ir_ld[1]),
    .ir_valid(ir_valid[1]), .redir_ack(redir_ack[1]), .busy(busy[1]),
    .fetch_cnt(cnt1)
  );

  fetch_sequencer #(.IM_LAT(3), .CNT_W(32)) u2 (
    .clk(clk), .reset(reset), .run(run), .ir_ack(ir_ack),
    .br_req(br_req), .jmp_req(jmp_req), .vec_req(vec_req), .jr_req(jr_req),
    .PC_ld(pc_ld[2]), .PC_inc(pc_inc[2]), .PC_sel(pc_sel[2]),
    .IM_cs(im_cs[2]), .IM_rd(im_rd[2]), .IR_ld(ir_ld[2]),
    .ir_valid(ir_valid[2]), .redir_ack(redir_ack[2]), .busy(busy[2]),
    .fetch_cnt(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // {PC_ld, PC_inc, PC_sel, IM_cs, IM_rd, IR_ld, ir_valid, redir_ack, busy}
  function automatic logic [9:0] act_vec(input int k);
    return {pc_ld[k], pc_inc[k], pc_sel[k], im_cs[k], im_rd[k], ir_ld[k],
            ir_valid[k], redir_ack[k], busy[k]};
  endfunction

  function automatic logic [31:0] act_cnt(input int k);
    case (k)
      0:       return {28'd0, cnt0};
      1:       return cnt1;
      default: return cnt2;
    endcase
  endfunction

  function automatic logic [9:0] exp_vec(input int k);
    logic [9:0] v;
    int lat;
    v   = '0;
    lat = k + 1;
    if (!reset && m_busy[k]) begin
      v[0] = 1'b1;
      if (m_pos[k] <= lat) begin
        v[5] = 1'b1;
        v[4] = 1'b1;
        if (m_pos[k] == lat) begin
          v[3] = 1'b1;
          v[8] = 1'b1;
        end
      end else begin
        v[2] = 1'b1;
        if (ir_ack && (vec_req || jr_req || jmp_req || br_req)) begin
          v[9] = 1'b1;
          v[1] = 1'b1;
          v[7:6] = vec_req ? 2'b10 : jr_req ? 2'b11 : jmp_req ? 2'b01 : 2'b00;
        end
      end
    end
    return v;
  endfunction

  task automatic advance(input int k);
    int lat;
    lat = k + 1;
    if (reset) begin
      m_busy[k] = 1'b0;
      m_cnt[k]  = '0;
    end else if (!m_busy[k]) begin
      if (run) begin
        m_busy[k] = 1'b1;
        m_pos[k]  = 0;
      end
    end else if (m_pos[k] < lat) begin
      m_pos[k] = m_pos[k] + 1;
    end else if (m_pos[k] == lat) begin
      m_pos[k] = m_pos[k] + 1;
      m_cnt[k] = (k == 0) ? ((m_cnt[k] + 32'd1) % 32'd16) : (m_cnt[k] + 32'd1);
    end else if (ir_ack) begin
      if (run) m_pos[k] = 0;
      else     m_busy[k] = 1'b0;
    end
  endtask

  // Per-cycle comparison against the model, then step the model.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("inst%0d strobes", k), 32'(act_vec(k)), 32'(exp_vec(k)));
      chk($sformatf("inst%0d fetch_cnt", k), act_cnt(k), reset ? 32'd0 : m_cnt[k]);
      advance(k);
    end
  end

  task automatic drive(input logic rst, input logic r, input logic a, input logic [3:0] rq);
    reset  = rst;
    run    = r;
    ir_ack = a;
    {vec_req, jr_req, jmp_req, br_req} = rq;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycle;
    drive(1'b1, 1'b0, 1'b0, 4'b0000);
    next_cycle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int k = 0; k < 3; k++) begin
      m_busy[k] = 1'b0;
      m_pos[k]  = 0;
      m_cnt[k]  = '0;
    end
    pats[0] = 4'b1111; sels[0] = 2'b10;
    pats[1] = 4'b0111; sels[1] = 2'b11;
    pats[2] = 4'b0011; sels[2] = 2'b01;
    pats[3] = 4'b0001; sels[3] = 2'b00;
    drive(1'b1, 1'b0, 1'b0, 4'b0000);

    // Reset then free-running fetch with ir_ack tied high.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("reset strobes u0", 32'(act_vec(0)), 32'd0);
      next_cycle();
    end
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 1'b1, 1'b1, 4'b0000);
      @(negedge clk);
      if (c == 0) chk("idle busy u0", 32'(busy[0]), 32'd0);
      if (c == 1) chk("fetch im_cs u0", 32'(im_cs[0]), 32'd1);
      if (c == 2) chk("latch ir_ld/pc_inc u0", {30'd0, ir_ld[0], pc_inc[0]}, 32'd3);
      if (c == 3) chk("hold ir_valid u0", 32'(ir_valid[0]), 32'd1);
      if (c == 4) chk("refetch im_cs u0", 32'(im_cs[0]), 32'd1);
      if (c == 3) chk("no early ir_ld u2", 32'(ir_ld[2]), 32'd0);
      if (c == 4) chk("ir_ld latency u2", 32'(ir_ld[2]), 32'd1);
      if (c == 9) chk("fetch_cnt after 3 u0", {28'd0, cnt0}, 32'd3);
      next_cycle();
    end

    // Stall in HOLD with a branch request outside the window, then reset in HOLD.
    reset_cycle();
    for (int c = 0; c < 12; c++) begin
      if (c < 10)       drive(1'b0, 1'b1, 1'b0, (c >= 1) ? 4'b0001 : 4'b0000);
      else if (c == 10) drive(1'b1, 1'b0, 1'b0, 4'b0000);
      else              drive(1'b0, 1'b0, 1'b0, 4'b0000);
      @(negedge clk);
      if (c >= 1 && c <= 9) chk("no redirect out of window u2", {30'd0, pc_ld[2], redir_ack[2]}, 32'd0);
      if (c >= 1 && c <= 4) chk("im_cs during access u2", 32'(im_cs[2]), 32'd1);
      if (c == 4) chk("ir_ld on 4th cycle u2", 32'(ir_ld[2]), 32'd1);
      if (c >= 5 && c <= 9) begin
        chk("stall ir_valid u2", 32'(ir_valid[2]), 32'd1);
        chk("stall strobes u2", {27'd0, pc_ld[2], pc_inc[2], im_cs[2], im_rd[2], ir_ld[2]}, 32'd0);
        chk("stall fetch_cnt u2", cnt2, 32'd1);
      end
      if (c == 10) chk("outputs in reset u2", 32'(act_vec(2)), 32'd0);
      if (c == 11) begin
        chk("post-reset ir_valid/busy u2", {30'd0, ir_valid[2], busy[2]}, 32'd0);
        chk("post-reset fetch_cnt u2", cnt2, 32'd0);
      end
      next_cycle();
    end

    // Redirect priority in HOLD with ir_ack, one pattern per fetch.
    for (int p = 0; p < 4; p++) begin
      reset_cycle();
      for (int c = 0; c < 4; c++) begin
        drive(1'b0, 1'b1, c == 3, (c == 3) ? pats[p] : ((c >= 1) ? 4'b0001 : 4'b0000));
        @(negedge clk);
        if (c == 1 || c == 2) chk("no redirect fetch/latch u0", {30'd0, pc_ld[0], redir_ack[0]}, 32'd0);
        if (c == 3) begin
          chk($sformatf("redirect pat%0d u0", p),
              {27'd0, pc_ld[0], redir_ack[0], pc_inc[0], pc_sel[0]}, {27'd0, 3'b110, sels[p]});
          chk("latch ignores redirect u1", {30'd0, pc_ld[1], pc_inc[1]}, 32'd1);
          chk("wait ignores redirect u2", {30'd0, pc_ld[2], redir_ack[2]}, 32'd0);
        end
        next_cycle();
      end
    end

    // run dropped mid-fetch completes the fetch then idles.
    reset_cycle();
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, c < 2, 1'b1, 4'b0000);
      @(negedge clk);
      if (c == 3) chk("latch after run drop u1", 32'(ir_ld[1]), 32'd1);
      if (c == 4) chk("hold after run drop u1", 32'(ir_valid[1]), 32'd1);
      if (c >= 5) chk("idle after run drop u1", {30'd0, busy[1], im_cs[1]}, 32'd0);
      next_cycle();
    end

    // 17 fetches on the 4-bit counter wraps to 1.
    reset_cycle();
    for (int c = 0; c < 52; c++) begin
      drive(1'b0, 1'b1, 1'b1, 4'b0000);
      @(negedge clk);
      if (c == 51) begin
        chk("wrap fetch_cnt u0", {28'd0, cnt0}, 32'd1);
        chk("fetch_cnt u1", cnt1, 32'd12);
        chk("fetch_cnt u2", cnt2, 32'd10);
      end
      next_cycle();
    end

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 60,
            {$urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30,
             $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30});
      next_cycle();
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
